// File: rtl/memory_stage_if.sv
`default_nettype none
// memory_stage_if: upstream execute, data-cache and writeback signals of the memory stage.
// Revision 1.0

interface memory_stage_if #(
  parameter int XLEN = 64
);
  logic            mem_enable;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] store_data;
  logic            is_load;
  logic            is_store;
  logic [1:0]      mem_size;
  logic            load_unsigned;
  logic [4:0]      dest_reg;

  logic            dc_req;
  logic            dc_we;
  logic [XLEN-1:0] dc_addr;
  logic [XLEN-1:0] dc_wdata;
  logic [1:0]      dc_size;
  logic            dc_ack;
  logic [XLEN-1:0] dc_rdata;

  logic [XLEN-1:0] wb_data;
  logic [4:0]      wb_rd;
  logic            wb_valid;
  logic            mem_busy;
  logic            misalign;

  // Environment side: execute stage plus data cache.
  modport master (
    output mem_enable, alu_result, store_data, is_load, is_store,
           mem_size, load_unsigned, dest_reg, dc_ack, dc_rdata,
    input  dc_req, dc_we, dc_addr, dc_wdata, dc_size,
           wb_data, wb_rd, wb_valid, mem_busy, misalign
  );

  modport slave (
    input  mem_enable, alu_result, store_data, is_load, is_store,
           mem_size, load_unsigned, dest_reg, dc_ack, dc_rdata,
    output dc_req, dc_we, dc_addr, dc_wdata, dc_size,
           wb_data, wb_rd, wb_valid, mem_busy, misalign
  );
endinterface

`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// memory_stage: pipeline memory stage with IDLE/REQ/RESP data-cache handshake,
// alignment check, load lane extraction and ALU pass-through. Revision 1.0

module memory_stage #(
  parameter int XLEN = 64
) (
  input  logic          clk,
  input  logic          reset,
  memory_stage_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [4:0]      rd_q, rd_d;
  logic            load_q, load_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_valid_q, wb_valid_d;
  logic            misalign_q, misalign_d;

  logic            accept;
  logic            is_mem;
  logic            misaligned;
  logic [XLEN-1:0] rep_data;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_val;

  assign accept = (state_q == S_IDLE) && bus.mem_enable;
  assign is_mem = bus.is_load | bus.is_store;

  always_comb begin
    misaligned = 1'b0;
    case (bus.mem_size)
      2'd1:    misaligned = bus.alu_result[0];
      2'd2:    misaligned = |bus.alu_result[1:0];
      2'd3:    misaligned = |bus.alu_result[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Store data is replicated into every lane so the cache can pick any byte enable.
  always_comb begin
    rep_data = bus.store_data;
    case (bus.mem_size)
      2'd0: for (int i = 0; i < XLEN; i++) rep_data[i] = bus.store_data[i % 8];
      2'd1: for (int i = 0; i < XLEN; i++) rep_data[i] = bus.store_data[i % 16];
      2'd2: for (int i = 0; i < XLEN; i++) rep_data[i] = bus.store_data[i % 32];
      default: rep_data = bus.store_data;
    endcase
  end

  assign shifted = bus.dc_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    load_val = bus.dc_rdata;
    case (size_q)
      2'd0: load_val = {{(XLEN-8){~uns_q & shifted[7]}}, shifted[7:0]};
      2'd1: load_val = {{(XLEN-16){~uns_q & shifted[15]}}, shifted[15:0]};
      2'd2: load_val = {{(XLEN-32){~uns_q & shifted[31]}}, shifted[31:0]};
      default: load_val = bus.dc_rdata;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      load_q     <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      load_q     <= load_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_valid_q <= wb_valid_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mem && !misaligned) state_d = S_REQ;
      S_REQ:   if (bus.dc_ack) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    load_d     = load_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_valid_d = 1'b0;
    misalign_d = 1'b0;
    if (accept) begin
      addr_d  = bus.alu_result;
      wdata_d = rep_data;
      size_d  = bus.mem_size;
      uns_d   = bus.load_unsigned;
      rd_d    = bus.dest_reg;
      load_d  = bus.is_load;
      if (!is_mem) begin
        wb_valid_d = 1'b1;
        wb_data_d  = bus.alu_result;
        wb_rd_d    = bus.dest_reg;
      end else if (misaligned) begin
        misalign_d = 1'b1;
      end
    end
    // Load data is captured in the ack cycle so the writeback pulse lands in RESP.
    if ((state_q == S_REQ) && bus.dc_ack && load_q) begin
      wb_valid_d = 1'b1;
      wb_data_d  = load_val;
      wb_rd_d    = rd_q;
    end
  end

  always_comb begin
    bus.dc_req   = 1'b0;
    bus.dc_we    = 1'b0;
    bus.mem_busy = 1'b0;
    case (state_q)
      S_REQ: begin
        bus.dc_req   = 1'b1;
        bus.dc_we    = ~load_q;
        bus.mem_busy = 1'b1;
      end
      S_RESP:  bus.mem_busy = 1'b1;
      default: bus.mem_busy = 1'b0;
    endcase
  end

  assign bus.dc_addr  = addr_q;
  assign bus.dc_wdata = wdata_q;
  assign bus.dc_size  = size_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.misalign = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// tb_memory_stage: directed vector table, corner sequences and randomized ops
// checked against an arithmetic reference model. Revision 1.0

module tb_memory_stage;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_MIS   = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_stage_if #(.XLEN(64)) bus();
  memory_stage #(.XLEN(64)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] last_wb;
  logic [4:0]  last_rd;

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] sd;
    logic [4:0]  rd;
    int          wait_n;
    logic [63:0] rdata;
    int          kind;
    logic [63:0] exp_wb;
    logic [63:0] exp_wd;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] sd, input logic [4:0] rd);
    bus.mem_enable    = 1'b1;
    bus.is_load       = ld;
    bus.is_store      = st;
    bus.mem_size      = sz;
    bus.load_unsigned = uns;
    bus.alu_result    = addr;
    bus.store_data    = sd;
    bus.dest_reg      = rd;
  endtask

  // Reference: byte count, lane offset and sign extension from plain arithmetic.
  function automatic void model(input logic ld, input logic st, input logic [1:0] sz,
                                input logic uns, input logic [63:0] addr, input logic [63:0] sd,
                                input logic [63:0] rdata, output int kind,
                                output logic [63:0] wb, output logic [63:0] wd);
    int nbytes;
    int bits;
    logic [63:0] mask;
    logic [63:0] lane;
    nbytes = 1 << sz;
    bits   = 8 * nbytes;
    mask   = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
    wb = 64'd0;
    wd = 64'd0;
    if (!ld && !st) begin
      kind = K_ALU;
      wb   = addr;
    end else if ((addr % 64'(nbytes)) != 64'd0) begin
      kind = K_MIS;
    end else if (ld) begin
      kind = K_LOAD;
      lane = (rdata >> (8 * (addr % 8))) & mask;
      if (bits < 64 && !uns && lane >= (64'd1 << (bits - 1)))
        lane = lane - (64'd1 << bits);
      wb = lane;
    end else begin
      kind = K_STORE;
      lane = sd & mask;
      for (int k = 0; k < 8 / nbytes; k++) wd = wd | (lane << (k * bits));
    end
  endfunction

  task automatic do_op(input vec_t v);
    drive_op(v.ld, v.st, v.sz, v.uns, v.addr, v.sd, v.rd);
    tick;
    bus.mem_enable = 1'b0;
    case (v.kind)
      K_ALU: begin
        chk("alu_wb_valid", 64'(bus.wb_valid), 64'd1);
        chk("alu_wb_data", bus.wb_data, v.exp_wb);
        chk("alu_wb_rd", 64'(bus.wb_rd), 64'(v.rd));
        chk("alu_no_req", 64'(bus.dc_req), 64'd0);
        chk("alu_not_busy", 64'(bus.mem_busy), 64'd0);
        last_wb = v.exp_wb;
        last_rd = v.rd;
        tick;
        chk("alu_pulse_end", 64'(bus.wb_valid), 64'd0);
        chk("alu_hold", bus.wb_data, last_wb);
      end
      K_MIS: begin
        chk("mis_pulse", 64'(bus.misalign), 64'd1);
        chk("mis_no_req", 64'(bus.dc_req), 64'd0);
        chk("mis_not_busy", 64'(bus.mem_busy), 64'd0);
        chk("mis_no_wb", 64'(bus.wb_valid), 64'd0);
        tick;
        chk("mis_pulse_end", 64'(bus.misalign), 64'd0);
        chk("mis_no_req2", 64'(bus.dc_req), 64'd0);
        chk("mis_hold_wb", bus.wb_data, last_wb);
      end
      default: begin
        chk("mem_req", 64'(bus.dc_req), 64'd1);
        chk("mem_we", 64'(bus.dc_we), 64'(v.kind == K_STORE));
        chk("mem_addr", bus.dc_addr, v.addr);
        chk("mem_size", 64'(bus.dc_size), 64'(v.sz));
        chk("mem_busy", 64'(bus.mem_busy), 64'd1);
        if (v.kind == K_STORE) chk("mem_wdata", bus.dc_wdata, v.exp_wd);
        for (int i = 0; i < v.wait_n; i++) begin
          bus.dc_ack = 1'b0;
          tick;
          chk("req_hold", 64'(bus.dc_req), 64'd1);
          chk("addr_hold", bus.dc_addr, v.addr);
          if (v.kind == K_STORE) chk("wdata_hold", bus.dc_wdata, v.exp_wd);
        end
        bus.dc_ack   = 1'b1;
        bus.dc_rdata = v.rdata;
        tick;
        bus.dc_ack   = 1'b0;
        bus.dc_rdata = {$urandom, $urandom};
        chk("resp_req_low", 64'(bus.dc_req), 64'd0);
        chk("resp_busy", 64'(bus.mem_busy), 64'd1);
        chk("resp_wb_valid", 64'(bus.wb_valid), 64'(v.kind == K_LOAD));
        if (v.kind == K_LOAD) begin
          chk("load_data", bus.wb_data, v.exp_wb);
          chk("load_rd", 64'(bus.wb_rd), 64'(v.rd));
          last_wb = v.exp_wb;
          last_rd = v.rd;
        end else begin
          chk("store_hold_wb", bus.wb_data, last_wb);
        end
        tick;
        chk("done_idle", 64'(bus.mem_busy), 64'd0);
        chk("done_no_wb", 64'(bus.wb_valid), 64'd0);
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int pulses;
    int reqs;
    int r;

    tbl[0]  = '{0, 0, 2'd0, 0, 64'h1234, 64'h0, 5'd5, 0, 64'h0, K_ALU, 64'h1234, 64'h0};
    tbl[1]  = '{1, 0, 2'd0, 0, 64'h1003, 64'h0, 5'd7, 3, 64'h0000_0000_8000_0000, K_LOAD, 64'hFFFF_FFFF_FFFF_FF80, 64'h0};
    tbl[2]  = '{1, 0, 2'd0, 1, 64'h1003, 64'h0, 5'd7, 3, 64'h0000_0000_8000_0000, K_LOAD, 64'h80, 64'h0};
    tbl[3]  = '{0, 1, 2'd2, 0, 64'h2004, 64'h1234_5678_DEAD_BEEF, 5'd0, 2, 64'h0, K_STORE, 64'h0, 64'hDEAD_BEEF_DEAD_BEEF};
    tbl[4]  = '{1, 0, 2'd3, 0, 64'h3004, 64'h0, 5'd9, 0, 64'h0, K_MIS, 64'h0, 64'h0};
    tbl[5]  = '{1, 0, 2'd1, 0, 64'h4006, 64'h0, 5'd10, 0, 64'h8001_0000_0000_0000, K_LOAD, 64'hFFFF_FFFF_FFFF_8001, 64'h0};
    tbl[6]  = '{1, 0, 2'd2, 1, 64'h5000, 64'h0, 5'd11, 1, 64'h1111_1111_F000_000F, K_LOAD, 64'hF000_000F, 64'h0};
    tbl[7]  = '{1, 0, 2'd2, 0, 64'h5000, 64'h0, 5'd12, 1, 64'h1111_1111_F000_000F, K_LOAD, 64'hFFFF_FFFF_F000_000F, 64'h0};
    tbl[8]  = '{1, 0, 2'd3, 1, 64'h6008, 64'h0, 5'd13, 2, 64'h8765_4321_0FED_CBA9, K_LOAD, 64'h8765_4321_0FED_CBA9, 64'h0};
    tbl[9]  = '{1, 1, 2'd0, 0, 64'h7001, 64'h0, 5'd14, 0, 64'h0000_0000_0000_7F00, K_LOAD, 64'h7F, 64'h0};
    tbl[10] = '{0, 1, 2'd0, 0, 64'h8005, 64'hAB, 5'd0, 1, 64'h0, K_STORE, 64'h0, 64'hABAB_ABAB_ABAB_ABAB};
    tbl[11] = '{0, 1, 2'd1, 0, 64'h9001, 64'h0, 5'd0, 0, 64'h0, K_MIS, 64'h0, 64'h0};
    tbl[12] = '{0, 1, 2'd1, 0, 64'hA002, 64'h1234_5678_9ABC_CDEF, 5'd0, 0, 64'h0, K_STORE, 64'h0, 64'hCDEF_CDEF_CDEF_CDEF};
    tbl[13] = '{1, 0, 2'd2, 1, 64'hB006, 64'h0, 5'd15, 0, 64'h0, K_MIS, 64'h0, 64'h0};
    tbl[14] = '{0, 1, 2'd3, 0, 64'hC008, 64'h0123_4567_89AB_CDEF, 5'd0, 4, 64'h0, K_STORE, 64'h0, 64'h0123_4567_89AB_CDEF};
    tbl[15] = '{0, 0, 2'd3, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 5'd31, 0, 64'h0, K_ALU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    tbl[16] = '{1, 0, 2'd0, 0, 64'h010F, 64'h0, 5'd1, 1, 64'hFF00_0000_0000_0000, K_LOAD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    tbl[17] = '{1, 0, 2'd2, 0, 64'h0204, 64'h0, 5'd2, 0, 64'h8000_0000_7FFF_FFFF, K_LOAD, 64'hFFFF_FFFF_8000_0000, 64'h0};

    reset             = 1'b1;
    bus.mem_enable    = 1'b0;
    bus.alu_result    = '0;
    bus.store_data    = '0;
    bus.is_load       = 1'b0;
    bus.is_store      = 1'b0;
    bus.mem_size      = '0;
    bus.load_unsigned = 1'b0;
    bus.dest_reg      = '0;
    bus.dc_ack        = 1'b0;
    bus.dc_rdata      = '0;
    tick;
    tick;
    chk("rst_dc_req", 64'(bus.dc_req), 64'd0);
    chk("rst_dc_we", 64'(bus.dc_we), 64'd0);
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_misalign", 64'(bus.misalign), 64'd0);
    chk("rst_busy", 64'(bus.mem_busy), 64'd0);
    chk("rst_wb_data", bus.wb_data, 64'd0);
    chk("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
    chk("rst_dc_addr", bus.dc_addr, 64'd0);
    chk("rst_dc_wdata", bus.dc_wdata, 64'd0);
    chk("rst_dc_size", 64'(bus.dc_size), 64'd0);
    reset   = 1'b0;
    last_wb = '0;
    last_rd = '0;
    tick;

    for (int i = 0; i < 18; i++) do_op(tbl[i]);

    // Ack while idle must be ignored.
    bus.dc_ack   = 1'b1;
    bus.dc_rdata = 64'h5555_AAAA_5555_AAAA;
    tick;
    bus.dc_ack = 1'b0;
    chk("idle_ack_no_wb", 64'(bus.wb_valid), 64'd0);
    chk("idle_ack_no_busy", 64'(bus.mem_busy), 64'd0);
    chk("idle_ack_hold", bus.wb_data, last_wb);

    // Reset in REQ with same-cycle ack abandons the load.
    drive_op(1, 0, 2'd3, 0, 64'h40, 64'h0, 5'd4);
    tick;
    bus.mem_enable = 1'b0;
    chk("rmid_req", 64'(bus.dc_req), 64'd1);
    tick;
    reset        = 1'b1;
    bus.dc_ack   = 1'b1;
    bus.dc_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    tick;
    reset      = 1'b0;
    bus.dc_ack = 1'b0;
    chk("rmid_req_low", 64'(bus.dc_req), 64'd0);
    chk("rmid_not_busy", 64'(bus.mem_busy), 64'd0);
    chk("rmid_no_wb", 64'(bus.wb_valid), 64'd0);
    chk("rmid_wb_clr", bus.wb_data, 64'd0);
    tick;
    chk("rmid_no_wb2", 64'(bus.wb_valid), 64'd0);
    chk("rmid_req_low2", 64'(bus.dc_req), 64'd0);
    last_wb = '0;
    last_rd = '0;

    // Reset dominates a same-cycle accept.
    reset = 1'b1;
    drive_op(0, 0, 2'd0, 0, 64'h55, 64'h0, 5'd6);
    tick;
    reset          = 1'b0;
    bus.mem_enable = 1'b0;
    chk("rst_vs_en_wb", 64'(bus.wb_valid), 64'd0);
    chk("rst_vs_en_data", bus.wb_data, 64'd0);
    tick;
    chk("rst_vs_en_wb2", 64'(bus.wb_valid), 64'd0);

    // Back-to-back ALU ops, then a load with mem_enable held while busy.
    drive_op(0, 0, 2'd0, 0, 64'h11, 64'h0, 5'd1);
    tick;
    chk("b2b_wb1", 64'(bus.wb_valid), 64'd1);
    chk("b2b_data1", bus.wb_data, 64'h11);
    drive_op(0, 0, 2'd0, 0, 64'h22, 64'h0, 5'd2);
    tick;
    chk("b2b_wb2", 64'(bus.wb_valid), 64'd1);
    chk("b2b_data2", bus.wb_data, 64'h22);
    chk("b2b_rd2", 64'(bus.wb_rd), 64'd2);
    drive_op(1, 0, 2'd3, 0, 64'h100, 64'h0, 5'd3);
    tick;
    chk("b2b_load_req", 64'(bus.dc_req), 64'd1);
    pulses = int'(bus.wb_valid);
    reqs   = 0;
    for (int i = 0; i < 2; i++) begin
      bus.dc_ack     = 1'b0;
      bus.alu_result = 64'hDEAD0;
      tick;
      pulses += int'(bus.wb_valid);
      chk("b2b_addr_latched", bus.dc_addr, 64'h100);
    end
    bus.dc_ack   = 1'b1;
    bus.dc_rdata = 64'hCAFE_F00D_1234_5678;
    tick;
    bus.dc_ack     = 1'b0;
    bus.mem_enable = 1'b0;
    chk("b2b_load_data", bus.wb_data, 64'hCAFE_F00D_1234_5678);
    chk("b2b_load_rd", 64'(bus.wb_rd), 64'd3);
    pulses += int'(bus.wb_valid);
    for (int i = 0; i < 4; i++) begin
      tick;
      pulses += int'(bus.wb_valid);
      reqs   += int'(bus.dc_req);
    end
    chk("b2b_load_pulses", 64'(pulses), 64'd1);
    chk("b2b_no_reaccept", 64'(reqs), 64'd0);
    last_wb = 64'hCAFE_F00D_1234_5678;
    last_rd = 5'd3;

    // Randomized ops against the reference model.
    for (int n = 0; n < 150; n++) begin
      r        = int'($urandom_range(0, 3));
      v.ld     = (r == 1) || (r == 3);
      v.st     = (r == 2) || (r == 3);
      v.sz     = 2'($urandom_range(0, 3));
      v.uns    = 1'($urandom_range(0, 1));
      v.addr   = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~((64'd1 << v.sz) - 64'd1);
      v.sd     = {$urandom, $urandom};
      v.rd     = 5'($urandom_range(0, 31));
      v.wait_n = int'($urandom_range(0, 4));
      v.rdata  = {$urandom, $urandom};
      model(v.ld, v.st, v.sz, v.uns, v.addr, v.sd, v.rdata, v.kind, v.exp_wb, v.exp_wd);
      do_op(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: mem_enable  in  1  execute result valid; alu_result  in  XLEN  address or ALU value; store_data  in  XLEN  rs2 contents.
REQ-004 SHALL have ports: is_load  in  1; is_store  in  1; mem_size  in  2  (0=B, 1=H, 2=W, 3=D); load_unsigned  in  1; dest_reg  in  5  writeback index.
REQ-005 SHALL have ports: dc_req  out  1; dc_we  out  1; dc_addr  out  XLEN; dc_wdata  out  XLEN; dc_size  out  2; dc_ack  in  1; dc_rdata  in  XLEN.
REQ-006 SHALL have ports: wb_data  out  XLEN; wb_rd  out  5; wb_valid  out  1  one-cycle pulse; mem_busy  out  1  stall to upstream; misalign  out  1  one-cycle fault pulse.

Function
REQ-007 SHALL implement FSM states IDLE, REQ, RESP.
REQ-008 SHALL accept an op only in IDLE when mem_enable=1; mem_busy SHALL be 1 in REQ and RESP, 0 in IDLE.
REQ-009 SHALL latch alu_result, store_data, mem_size, load_unsigned, dest_reg, is_load, is_store on acceptance.
REQ-010 SHALL, for non-memory op (is_load=is_store=0), pulse wb_valid the cycle after acceptance with wb_data=alu_result, wb_rd=dest_reg, remaining in IDLE (1-cycle latency, back-to-back accept allowed).
REQ-011 SHALL treat is_load=is_store=1 as a load.
REQ-012 SHALL check alignment at acceptance: addr low bits nonzero for H (bit0), W (bits1:0), D (bits2:0) -> misalign pulse next cycle, no dc_req, no wb_valid, stay IDLE.
REQ-013 SHALL, for aligned memory op, go IDLE->REQ; dc_req=1 from the cycle after acceptance, held with stable dc_addr/dc_we/dc_wdata/dc_size until the cycle dc_ack=1.
REQ-014 SHALL drive dc_we=1 for stores, 0 for loads; dc_addr=latched alu_result; dc_size=latched mem_size; dc_wdata=store_data replicated across lanes per size.
REQ-015 SHALL, on dc_ack in REQ, drop dc_req next cycle and go to RESP; dc_ack outside REQ SHALL be ignored.
REQ-016 SHALL, in RESP, pulse wb_valid for loads (wb_rd=latched dest_reg) and return to IDLE; stores SHALL pass through RESP with wb_valid=0.
REQ-017 SHALL select load lane from dc_rdata by addr[2:0] and size; sign-extend to XLEN unless load_unsigned=1; D ignores load_unsigned.
REQ-018 SHALL capture dc_rdata in the dc_ack cycle; load latency = acceptance + N-cycle ack wait + 2.
REQ-019 SHALL ignore mem_enable while busy; upstream holds inputs while mem_busy=1.
REQ-020 SHALL hold wb_data/wb_rd between pulses; wb_valid SHALL never exceed one cycle per op.

Reset
REQ-021 SHALL, on reset=1 at a clock edge, enter IDLE and clear dc_req, dc_we, wb_valid, misalign, mem_busy, wb_data, wb_rd, dc_addr, dc_wdata, dc_size to 0.
REQ-022 SHALL abandon an in-flight REQ on reset (dc_req low next cycle, no wb_valid); reset SHALL dominate a same-cycle dc_ack or mem_enable.

Verification
REQ-023 ALU pass-through: mem_enable, alu_result=0x1234, dest_reg=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, dc_req never asserted.
REQ-024 Signed byte load: addr=0x1003, size=B, dc_ack after 3 cycles, dc_rdata=0x00000000_80000000 -> wb_data=0xFFFFFFFF_FFFFFF80; load_unsigned=1 -> 0x80.
REQ-025 Store word: addr=0x2004, store_data=0xDEADBEEF, size=W -> dc_req=1, dc_we=1, dc_wdata upper lane=0xDEADBEEF, held until ack; no wb_valid.
REQ-026 Misaligned: size=D, addr=0x3004 -> misalign pulse 1 cycle, dc_req=0, mem_busy=0.
REQ-027 Reset mid-op: load in REQ, reset=1 with dc_ack=1 same cycle -> next cycle IDLE, dc_req=0, wb_valid=0.
REQ-028 Back-to-back: two ALU ops consecutive cycles, then load with mem_enable held during busy -> two wb_valid pulses, load accepted once, exactly one further wb_valid.
